mux16_1: RTL and testbench
==========================

Name: mux16_1

Overview:
- Registered 16-to-1 word multiplexer: selects one of sixteen WIDTH-bit data inputs by a 4-bit select, gated by an enable.
- Result is captured in an output register.
- Used as a generic source-select block in the datapath, e.g. for register-file read or result selection.
- Built as a two-level tree of 4-to-1 muxes: four first-level, one second-level.

Parameters:
- WIDTH, 16, bit width of every data input and of the output.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in0 .. in15  input  WIDTH each  data inputs; inN is selected when sel == N
- en  input  1  enable; 1 = pass selected input, 0 = force output to zero
- sel  input  4  select index 0..15
- out  output  WIDTH  registered mux result
- Port order after clk/rst_n: in0..in15, en, sel, out.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset:
  - rst_n low clears out to 0 immediately, independent of clk.
  - out stays 0 while rst_n is low.
  - Deassertion takes effect at the first rising clk edge after rst_n goes high.
- Combinational tree:
  - Level 1, group g = 0..3: m[g] = in{4g + sel[1:0]}. Covers in0-3, in4-7, in8-11, in12-15.
  - Level 2: sel_word = m[sel[3:2]].
- Register, at each rising clk edge with rst_n high:
  - out <= en ? sel_word : 0.
- Latency: exactly 1 cycle from inputs/sel/en to out. No combinational path from inputs to out.
- All 16 sel codes are valid. No out-of-range case and no X propagation for known inputs.
- Changing sel, en or data inputs between edges has no effect until the next edge.
- Simultaneous change of sel and the selected data: out reflects the new sel and new data at the next edge.
- en low for one cycle: out is 0 for exactly that cycle, then resumes selection on the next enabled edge.
- Reset mid-operation: out clears at once. The first post-reset edge with en high loads the currently selected input.
- No handshake and no state machine: a single pipeline register stage only.

Decomposition:
- Shared package: the WIDTH default constant (16) and a SEL_W = 4 constant.
- Sub-module mux4_1 (parameter WIDTH; ports a, b, c, d, s[1:0], y), purely combinational.
- mux4_1 is instantiated five times: four leaf instances plus one root instance.
- The register and the enable gating live in mux16_1.

Test Plan:
- Reset:
  - rst_n low with in10 = 16'h00AB, sel = 4'hA, en = 1 -> out = 16'h0000 immediately and while held.
  - Release rst_n -> out = 16'h00AB after the first rising edge.
- Exhaustive select:
  - inN = N for N = 0..15 except in10 = 16'h00AB; en = 1.
  - Sweep sel 0..15, one per cycle -> out equals the selected value one cycle later: sel = 4'hA gives 16'h00AB, sel = 4'hF gives 16'h000F.
- Enable gating:
  - sel = 4'h5, in5 = 16'h0005, en toggled 1, 0, 1 -> out = 16'h0005, then 16'h0000, then 16'h0005 on successive edges.
- Latency/isolation:
  - Change in3 from 16'h0003 to 16'hBEEF mid-cycle with sel = 3 -> out stays 16'h0003 until the next rising edge, then becomes 16'hBEEF.
  - Changing in4 while sel = 3 never alters out.
- Async reset mid-run:
  - Assert rst_n low between edges while out = 16'h00AB -> out = 16'h0000 before the next edge.
- Tree boundaries:
  - sel = 3, 4, 11, 12 with distinct patterns (e.g. 16'hA5A5, 16'h5A5A) -> correct group/leaf chosen across every level-1 group boundary.

Source files
------------

// File: rtl/mux16_1_pkg.sv
// Shared constants for the registered 16-to-1 word multiplexer.
package mux16_1_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int SEL_W     = 4;

endpackage

// File: rtl/mux16_1_mux4.sv
// Combinational 4-to-1 word multiplexer used as the tree node of mux16_1.
module mux4_1 #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       s,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = a;
        unique case (s)
            2'd0: y = a;
            2'd1: y = b;
            2'd2: y = c;
            2'd3: y = d;
        endcase
    end

endmodule

// File: rtl/mux16_1.sv
// Registered 16-to-1 word multiplexer: two-level 4:1 tree, enable gate,
// single output register.
module mux16_1
    import mux16_1_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [WIDTH-1:0] in4,
    input  logic [WIDTH-1:0] in5,
    input  logic [WIDTH-1:0] in6,
    input  logic [WIDTH-1:0] in7,
    input  logic [WIDTH-1:0] in8,
    input  logic [WIDTH-1:0] in9,
    input  logic [WIDTH-1:0] in10,
    input  logic [WIDTH-1:0] in11,
    input  logic [WIDTH-1:0] in12,
    input  logic [WIDTH-1:0] in13,
    input  logic [WIDTH-1:0] in14,
    input  logic [WIDTH-1:0] in15,
    input  logic             en,
    input  logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] m0, m1, m2, m3;
    logic [WIDTH-1:0] sel_word;
    logic [WIDTH-1:0] out_d, out_q;

    // Leaves pick within a group of four using the low select bits
    mux4_1 #(.WIDTH(WIDTH)) u_leaf0 (
        .a(in0), .b(in1), .c(in2), .d(in3),
        .s(sel[1:0]), .y(m0)
    );

    mux4_1 #(.WIDTH(WIDTH)) u_leaf1 (
        .a(in4), .b(in5), .c(in6), .d(in7),
        .s(sel[1:0]), .y(m1)
    );

    mux4_1 #(.WIDTH(WIDTH)) u_leaf2 (
        .a(in8), .b(in9), .c(in10), .d(in11),
        .s(sel[1:0]), .y(m2)
    );

    mux4_1 #(.WIDTH(WIDTH)) u_leaf3 (
        .a(in12), .b(in13), .c(in14), .d(in15),
        .s(sel[1:0]), .y(m3)
    );

    mux4_1 #(.WIDTH(WIDTH)) u_root (
        .a(m0), .b(m1), .c(m2), .d(m3),
        .s(sel[3:2]), .y(sel_word)
    );

    always_comb begin
        out_d = '0;
        if (en) begin
            out_d = sel_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_mux16_1.sv
// Self-checking bench for mux16_1: directed table, corner sequences,
// randomized traffic against an array-indexing reference model.
module tb_mux16_1;

    typedef struct {
        logic [3:0]  sel;
        logic        en;
        logic [15:0] exp;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] din [16];
    logic        en;
    logic [3:0]  sel;
    logic [15:0] out;

    int checks;
    int failures;

    mux16_1 #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in0(din[0]), .in1(din[1]), .in2(din[2]), .in3(din[3]),
        .in4(din[4]), .in5(din[5]), .in6(din[6]), .in7(din[7]),
        .in8(din[8]), .in9(din[9]), .in10(din[10]), .in11(din[11]),
        .in12(din[12]), .in13(din[13]), .in14(din[14]), .in15(din[15]),
        .en(en), .sel(sel), .out(out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [15:0] model(input logic [15:0] d [16],
                                          input logic [3:0] s,
                                          input logic e);
        return e ? d[s] : 16'h0000;
    endfunction

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t        tbl [$];
    logic [15:0] e;

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b1;
        for (int n = 0; n < 16; n++) din[n] = 16'(n);
        din[10] = 16'h00AB;
        sel = 4'hA;
        en  = 1'b1;

        // Reset asserted before any clock edge
        #1 rst_n = 1'b0;
        #1 chk("reset_immediate", out, 16'h0000);
        tick();
        chk("reset_held1", out, 16'h0000);
        tick();
        chk("reset_held2", out, 16'h0000);
        rst_n = 1'b1;
        #2 chk("reset_release_pre_edge", out, 16'h0000);
        tick();
        chk("reset_release_first_edge", out, 16'h00AB);

        // Directed table: exhaustive sweep then enable gating
        for (int n = 0; n < 16; n++)
            tbl.push_back('{sel: 4'(n), en: 1'b1,
                            exp: (n == 10) ? 16'h00AB : 16'(n)});
        tbl.push_back('{sel: 4'h5, en: 1'b1, exp: 16'h0005});
        tbl.push_back('{sel: 4'h5, en: 1'b0, exp: 16'h0000});
        tbl.push_back('{sel: 4'h5, en: 1'b1, exp: 16'h0005});
        for (int i = 0; i < tbl.size(); i++) begin
            sel = tbl[i].sel;
            en  = tbl[i].en;
            tick();
            chk($sformatf("table[%0d]_sel%0d_en%0d", i, tbl[i].sel,
                          tbl[i].en), out, tbl[i].exp);
        end

        // Latency and isolation
        sel = 4'h3;
        en  = 1'b1;
        tick();
        chk("lat_sel3", out, 16'h0003);
        din[3] = 16'hBEEF;
        #2 chk("lat_mid_cycle_hold", out, 16'h0003);
        din[4] = 16'h1234;
        tick();
        chk("lat_new_data", out, 16'hBEEF);
        din[4] = 16'h4321;
        #2 chk("iso_in4_mid", out, 16'hBEEF);
        tick();
        chk("iso_in4_edge", out, 16'hBEEF);

        // Simultaneous sel and data change
        sel = 4'h9;
        din[9] = 16'h7E57;
        tick();
        chk("sel_and_data", out, 16'h7E57);

        // Async reset mid-run
        sel = 4'hA;
        tick();
        chk("pre_async_reset", out, 16'h00AB);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_mid", out, 16'h0000);
        tick();
        chk("async_reset_held", out, 16'h0000);
        rst_n = 1'b1;
        tick();
        chk("post_reset_load", out, 16'h00AB);

        // Tree group boundaries
        din[3]  = 16'hA5A5;
        din[4]  = 16'h5A5A;
        din[11] = 16'hC3C3;
        din[12] = 16'h3C3C;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: sel = 4'd3;
                1: sel = 4'd4;
                2: sel = 4'd11;
                default: sel = 4'd12;
            endcase
            e = model(din, sel, 1'b1);
            tick();
            chk($sformatf("boundary_sel%0d", sel), out, e);
        end

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            for (int n = 0; n < 16; n++) din[n] = 16'($urandom);
            sel = 4'($urandom_range(0, 15));
            en  = ($urandom_range(0, 3) != 0);
            e   = model(din, sel, en);
            tick();
            chk($sformatf("rand[%0d]", i), out, e);
            if (i % 7 == 0) begin
                din[sel] = ~din[sel];
                sel = ~sel;
                en  = ~en;
                #2 chk($sformatf("rand_hold[%0d]", i), out, e);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
